// File: rtl/hdmi_colorbar_src.sv
// rtl/hdmi_colorbar_src.sv - raster timing and test-pattern source for the HDMI transmit stage
//
// Purpose: free-running h/v counters produce hsync/vsync/rgb_valid and a
// selectable 8-bit RGB test pattern. It also produces pixel coordinates and a
// frame-start strobe. Every output is registered from the counter state of the
// previous clock, so all outputs are mutually cycle-aligned.
//
// Ports:
//   vga_clk      in   pixel clock
//   sys_rst_n    in   asynchronous active-low reset
//   pat_sel      in   [1:0]  0 colorbar, 1 gray ramp, 2 checkerboard, 3 solid
//   solid_rgb    in   [23:0] {R,G,B} used when pat_sel=3
//   hsync        out  horizontal sync (SYNC_POL during pulse)
//   vsync        out  vertical sync (SYNC_POL during pulse)
//   rgb_valid    out  active video
//   rgb_red      out  [7:0]
//   rgb_green    out  [7:0]
//   rgb_blue     out  [7:0]
//   pix_x        out  [11:0] active column, 0 outside active video
//   pix_y        out  [11:0] active row, 0 outside active video
//   frame_start  out  one-clock pulse for h_cnt=0, v_cnt=0

module hdmi_colorbar_src #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [7:0]  rgb_red,
    output logic [7:0]  rgb_green,
    output logic [7:0]  rgb_blue,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start
);

    localparam logic [11:0] H_LAST     = 12'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [11:0] V_LAST     = 12'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] HA_START   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HA_END     = 12'(H_SYNC + H_BACK + H_VALID);
    localparam logic [11:0] VA_START   = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VA_END     = 12'(V_SYNC + V_BACK + V_VALID);
    localparam logic [11:0] BAR_LAST   = 12'(H_VALID / 8 - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q;
    logic [23:0] solid_q;

    logic        hsync_q, vsync_q, valid_q, sof_q;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] pix_x_q, pix_y_q;

    logic        h_wrap, h_act, v_act, act, sof;
    logic        hs_d, vs_d;
    logic [11:0] px_d, py_d;
    logic [23:0] bar_rgb;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    always_comb begin
        h_act = (h_cnt_q >= HA_START) && (h_cnt_q < HA_END);
        v_act = (v_cnt_q >= VA_START) && (v_cnt_q < VA_END);
        act   = h_act && v_act;
        sof   = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        hs_d  = (h_cnt_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_d  = (v_cnt_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        px_d  = act ? h_cnt_q - HA_START : 12'd0;
        py_d  = act ? v_cnt_q - VA_START : 12'd0;
    end

    // Bar position tracks the current h_cnt: it is held at zero outside the
    // active span, so the first active pixel of every line is bar 0 without
    // any division of pix_x.
    always_comb begin
        bar_cnt_d = 12'd0;
        bar_idx_d = 3'd0;
        if (h_act) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = 12'd0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 12'd1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx_q)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (act) begin
            case (pat_q)
                2'd0: rgb_d = bar_rgb;
                2'd1: rgb_d = {3{px_d[7:0]}};
                2'd2: rgb_d = (px_d[5] ^ py_d[5]) ? 24'hFFFFFF : 24'h000000;
                default: rgb_d = solid_q;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
            bar_cnt_q <= 12'd0;
            bar_idx_q <= 3'd0;
            pat_q     <= 2'd0;
            solid_q   <= 24'h000000;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            valid_q   <= 1'b0;
            rgb_q     <= 24'h000000;
            pix_x_q   <= 12'd0;
            pix_y_q   <= 12'd0;
            sof_q     <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            // Pattern controls are only taken at frame start (never active
            // video), so a mid-frame change cannot tear the picture.
            if (sof) begin
                pat_q   <= pat_sel;
                solid_q <= solid_rgb;
            end
            hsync_q   <= hs_d;
            vsync_q   <= vs_d;
            valid_q   <= act;
            rgb_q     <= rgb_d;
            pix_x_q   <= px_d;
            pix_y_q   <= py_d;
            sof_q     <= sof;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_valid   = valid_q;
    assign rgb_red     = rgb_q[23:16];
    assign rgb_green   = rgb_q[15:8];
    assign rgb_blue    = rgb_q[7:0];
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = sof_q;

endmodule

// File: tb/tb_hdmi_colorbar_src.sv
// tb/tb_hdmi_colorbar_src.sv - directed self-checking bench for hdmi_colorbar_src

module tb_hdmi_colorbar_src;

    // Reduced raster so that several frames fit in a short run.
    // H: 4+4+320+4 = 332 clocks/line, active h 8..327, BAR_W = 40
    // V: 2+3+34+2  = 41 lines/frame, active v 5..38, frame = 13612 clocks
    localparam int HT = 332;
    localparam int FT = 13612;
    localparam int A0 = 5 * HT + 8;   // output cycle of pix (0,0)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        hsync, vsync, rgb_valid, frame_start;
    logic [7:0]  rgb_red, rgb_green, rgb_blue;
    logic [11:0] pix_x, pix_y;

    int checks = 0;
    int failures = 0;
    int n = -1;
    int cnt_valid = 0, cnt_hs = 0, cnt_vs = 0, cnt_sof = 0;

    hdmi_colorbar_src #(
        .H_SYNC(4), .H_BACK(4), .H_VALID(320), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(3), .V_VALID(34), .V_FRONT(2),
        .SYNC_POL(1'b1)
    ) dut (
        .vga_clk     (clk),
        .sys_rst_n   (rst_n),
        .pat_sel     (pat_sel),
        .solid_rgb   (solid_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb_valid   (rgb_valid),
        .rgb_red     (rgb_red),
        .rgb_green   (rgb_green),
        .rgb_blue    (rgb_blue),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to output cycle 'target' (sampled on the falling edge),
    // accumulating per-cycle statistics along the way.
    task automatic goto_cyc(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
            if (rgb_valid)   cnt_valid++;
            if (hsync)       cnt_hs++;
            if (vsync)       cnt_vs++;
            if (frame_start) cnt_sof++;
        end
    endtask

    task automatic restart_count();
        n = -1;
        cnt_valid = 0; cnt_hs = 0; cnt_vs = 0; cnt_sof = 0;
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, rgb_red, rgb_green, rgb_blue};
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hsync", {31'd0, hsync}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_valid", {31'd0, rgb_valid}, 32'd0);
        chk("rst_rgb", rgb_now(), 32'h0);
        chk("rst_sof", {31'd0, frame_start}, 32'd0);
        chk("rst_pix", {8'd0, pix_x, pix_y}, 32'd0);

        rst_n = 1'b1;
        restart_count();

        // Frame 1: colorbar and timing
        goto_cyc(0);
        chk("f1_sof", {31'd0, frame_start}, 32'd1);
        chk("f1_hs0", {31'd0, hsync}, 32'd1);
        chk("f1_vs0", {31'd0, vsync}, 32'd1);
        goto_cyc(1);
        chk("f1_sof_1clk", {31'd0, frame_start}, 32'd0);
        goto_cyc(3);
        chk("hs_last", {31'd0, hsync}, 32'd1);
        goto_cyc(4);
        chk("hs_end", {31'd0, hsync}, 32'd0);
        goto_cyc(HT);
        chk("hs_line1", {31'd0, hsync}, 32'd1);
        chk("vs_line1", {31'd0, vsync}, 32'd1);
        goto_cyc(2 * HT);
        chk("vs_end", {31'd0, vsync}, 32'd0);
        goto_cyc(A0 - 1);
        chk("pre_active", {31'd0, rgb_valid}, 32'd0);
        goto_cyc(A0);
        chk("first_valid", {31'd0, rgb_valid}, 32'd1);
        chk("first_pix", {8'd0, pix_x, pix_y}, 32'd0);
        chk("bar0", rgb_now(), 32'hFFFFFF);
        goto_cyc(A0 + 39);
        chk("bar0_end", rgb_now(), 32'hFFFFFF);
        goto_cyc(A0 + 40);
        chk("bar1", rgb_now(), 32'hFFFF00);
        goto_cyc(A0 + 279);
        chk("bar6", rgb_now(), 32'h0000FF);
        goto_cyc(A0 + 280);
        chk("bar7", rgb_now(), 32'h000000);
        goto_cyc(A0 + 319);
        chk("last_valid", {31'd0, rgb_valid}, 32'd1);
        chk("last_pix_x", {20'd0, pix_x}, 32'd319);
        goto_cyc(A0 + 320);
        chk("after_line_valid", {31'd0, rgb_valid}, 32'd0);
        chk("after_line_rgb", rgb_now(), 32'h0);
        chk("after_line_px", {20'd0, pix_x}, 32'd0);

        // Mid-frame switch to solid: current frame must stay colorbar
        goto_cyc(15 * HT);
        pat_sel = 2'd3;
        solid_rgb = 24'h123456;
        goto_cyc(20 * HT + 8);
        chk("mid_still_bar", rgb_now(), 32'hFFFFFF);
        chk("mid_pix_y", {20'd0, pix_y}, 32'd15);
        goto_cyc(38 * HT + 8);
        chk("lastline_bar", rgb_now(), 32'hFFFFFF);
        goto_cyc(FT - 1);
        chk("frame_valid_cnt", cnt_valid, 32'd10880);
        chk("frame_hs_cnt", cnt_hs, 32'd164);
        chk("frame_vs_cnt", cnt_vs, 32'd664);
        chk("frame_sof_cnt", cnt_sof, 32'd1);
        goto_cyc(FT);
        chk("f2_sof", {31'd0, frame_start}, 32'd1);

        // Frame 2: solid
        goto_cyc(FT + A0);
        chk("solid_first", rgb_now(), 32'h123456);
        goto_cyc(FT + 38 * HT + 8 + 319);
        chk("solid_last", rgb_now(), 32'h123456);
        pat_sel = 2'd2;

        // Frame 3: checkerboard
        goto_cyc(2 * FT + A0 + 31);
        chk("chk_31_0", rgb_now(), 32'h000000);
        goto_cyc(2 * FT + A0 + 32);
        chk("chk_32_0", rgb_now(), 32'hFFFFFF);
        goto_cyc(2 * FT + 37 * HT + 8);
        chk("chk_0_32", rgb_now(), 32'hFFFFFF);
        goto_cyc(2 * FT + 37 * HT + 8 + 32);
        chk("chk_32_32_pix", {8'd0, pix_x, pix_y}, {8'd0, 12'd32, 12'd32});
        chk("chk_32_32", rgb_now(), 32'h000000);
        pat_sel = 2'd1;

        // Frame 4: gray ramp, then reset mid-frame
        goto_cyc(3 * FT + A0 + 255);
        chk("gray_255", rgb_now(), 32'hFFFFFF);
        goto_cyc(3 * FT + A0 + 256);
        chk("gray_256", rgb_now(), 32'h000000);
        goto_cyc(3 * FT + A0 + 300);
        chk("gray_300", rgb_now(), 32'h2C2C2C);
        pat_sel = 2'd0;
        goto_cyc(3 * FT + 25 * HT + 8 + 200);
        chk("pre_rst_pix", {8'd0, pix_x, pix_y}, {8'd0, 12'd200, 12'd20});
        chk("pre_rst_rgb", rgb_now(), 32'hC8C8C8);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, rgb_valid}, 32'd0);
        chk("async_rgb", rgb_now(), 32'h0);
        chk("async_pix", {8'd0, pix_x, pix_y}, 32'd0);
        chk("async_sync", {30'd0, hsync, vsync}, 32'd0);
        chk("async_sof", {31'd0, frame_start}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        restart_count();
        goto_cyc(0);
        chk("rst2_sof", {31'd0, frame_start}, 32'd1);
        chk("rst2_sync", {30'd0, hsync, vsync}, 32'd3);
        goto_cyc(A0);
        chk("rst2_pix", {7'd0, rgb_valid, pix_x, pix_y}, {7'd0, 1'b1, 24'd0});
        chk("rst2_bar0", rgb_now(), 32'hFFFFFF);
        goto_cyc(A0 + 40);
        chk("rst2_bar1", rgb_now(), 32'hFFFF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
